// File: rtl/copro_mailbox.sv
// Two-way byte mailbox between the C64 host and the 6809 coprocessor.
// The host pushes commands into CMD, which the 6809 drains. The 6809 pushes
// responses into RSP, which the host drains. Both FIFOs are show-ahead.
// Each side sees a data register and a status/control register.

module copro_mailbox_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clock,
  input  logic       _reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       ovf_evt,
  output logic       udf_evt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Occupancy decode, push/pop acceptance and error events.
  // A flush wins over a same-cycle peer push: the byte is simply discarded.
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  always_comb begin
    empty     = (count_r == CNT_ZERO);
    full      = (count_r == CNT_FULL);
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    ovf_evt   = 1'b0;
    udf_evt   = 1'b0;
    if (flush) begin
      push_ok_s = 1'b0;
      pop_ok_s  = 1'b0;
    end else begin
      push_ok_s = push & (~full | pop);
      pop_ok_s  = pop & ~empty;
      ovf_evt   = push & full & ~pop;
      udf_evt   = pop & empty;
    end
    if (empty) begin
      head = 8'h00;
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

  // Storage array; contents are only meaningful below count_r, so no reset.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

module copro_mailbox #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clock,
  input  logic       _reset,
  input  logic       host_cs,
  input  logic       host_a,
  input  logic       host_r_w,
  input  logic       host_stb,
  input  logic [7:0] host_din,
  output logic [7:0] host_dout,
  output logic       _irq_host,
  input  logic       copro_cs,
  input  logic       copro_a,
  input  logic       copro_r_w,
  input  logic       copro_stb,
  input  logic [7:0] copro_din,
  output logic [7:0] copro_dout,
  output logic       _irq_09
);

  logic       host_commit_s;
  logic       host_data_wr_s;
  logic       host_data_rd_s;
  logic       host_stat_wr_s;
  logic       host_stat_rd_s;
  logic       copro_commit_s;
  logic       copro_data_wr_s;
  logic       copro_data_rd_s;
  logic       copro_stat_wr_s;
  logic       copro_stat_rd_s;
  logic       cmd_flush_s;
  logic       rsp_flush_s;

  logic [7:0] cmd_head_s;
  logic       cmd_empty_s;
  logic       cmd_full_s;
  logic       cmd_ovf_evt_s;
  logic       cmd_udf_evt_s;
  logic [7:0] rsp_head_s;
  logic       rsp_empty_s;
  logic       rsp_full_s;
  logic       rsp_ovf_evt_s;
  logic       rsp_udf_evt_s;

  logic       host_ovf_r;
  logic       host_udf_r;
  logic       host_irq_en_r;
  logic       copro_ovf_r;
  logic       copro_udf_r;
  logic       copro_irq_en_r;
  logic       irq_host_r;
  logic       irq_09_r;
  logic [7:0] host_status_s;
  logic [7:0] copro_status_s;

  // Access decode: a strobe only counts when its side's chip select is high.
  // Writing status with bit7 set flushes the writer's own receive FIFO.
  always_comb begin
    host_commit_s   = host_stb & host_cs;
    host_data_wr_s  = host_commit_s & ~host_a & ~host_r_w;
    host_data_rd_s  = host_commit_s & ~host_a &  host_r_w;
    host_stat_wr_s  = host_commit_s &  host_a & ~host_r_w;
    host_stat_rd_s  = host_commit_s &  host_a &  host_r_w;
    copro_commit_s  = copro_stb & copro_cs;
    copro_data_wr_s = copro_commit_s & ~copro_a & ~copro_r_w;
    copro_data_rd_s = copro_commit_s & ~copro_a &  copro_r_w;
    copro_stat_wr_s = copro_commit_s &  copro_a & ~copro_r_w;
    copro_stat_rd_s = copro_commit_s &  copro_a &  copro_r_w;
    cmd_flush_s     = copro_stat_wr_s & copro_din[7];
    rsp_flush_s     = host_stat_wr_s & host_din[7];
  end

  copro_mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_cmd_fifo (
    .clock   (clock),
    ._reset  (_reset),
    .push    (host_data_wr_s),
    .pop     (copro_data_rd_s),
    .flush   (cmd_flush_s),
    .din     (host_din),
    .head    (cmd_head_s),
    .empty   (cmd_empty_s),
    .full    (cmd_full_s),
    .ovf_evt (cmd_ovf_evt_s),
    .udf_evt (cmd_udf_evt_s)
  );

  copro_mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rsp_fifo (
    .clock   (clock),
    ._reset  (_reset),
    .push    (copro_data_wr_s),
    .pop     (host_data_rd_s),
    .flush   (rsp_flush_s),
    .din     (copro_din),
    .head    (rsp_head_s),
    .empty   (rsp_empty_s),
    .full    (rsp_full_s),
    .ovf_evt (rsp_ovf_evt_s),
    .udf_evt (rsp_udf_evt_s)
  );

  // Sticky error flags and interrupt enables.
  // Overflow belongs to the writer, underflow to the reader.
  // A committed status read clears that side's flags.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      host_ovf_r     <= 1'b0;
      host_udf_r     <= 1'b0;
      host_irq_en_r  <= 1'b0;
      copro_ovf_r    <= 1'b0;
      copro_udf_r    <= 1'b0;
      copro_irq_en_r <= 1'b0;
    end else begin
      if (cmd_ovf_evt_s) begin
        host_ovf_r <= 1'b1;
      end else if (host_stat_rd_s) begin
        host_ovf_r <= 1'b0;
      end
      if (rsp_udf_evt_s) begin
        host_udf_r <= 1'b1;
      end else if (host_stat_rd_s) begin
        host_udf_r <= 1'b0;
      end
      if (rsp_ovf_evt_s) begin
        copro_ovf_r <= 1'b1;
      end else if (copro_stat_rd_s) begin
        copro_ovf_r <= 1'b0;
      end
      if (cmd_udf_evt_s) begin
        copro_udf_r <= 1'b1;
      end else if (copro_stat_rd_s) begin
        copro_udf_r <= 1'b0;
      end
      if (host_stat_wr_s) begin
        host_irq_en_r <= host_din[0];
      end
      if (copro_stat_wr_s) begin
        copro_irq_en_r <= copro_din[0];
      end
    end
  end

  // Interrupt outputs lag the FIFO/enable state by one clock.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      irq_host_r <= 1'b1;
      irq_09_r   <= 1'b1;
    end else begin
      irq_host_r <= ~(host_irq_en_r & ~rsp_empty_s);
      irq_09_r   <= ~(copro_irq_en_r & ~cmd_empty_s);
    end
  end

  // Status bytes and read data mux; reads are show-ahead, so data is the head.
  // The "rx" FIFO is the one a side pops; "peer rx" is the one it pushes.
  always_comb begin
    host_status_s  = {~rsp_empty_s, ~cmd_full_s, host_ovf_r, host_udf_r,
                      2'b00, ~cmd_empty_s, host_irq_en_r};
    copro_status_s = {~cmd_empty_s, ~rsp_full_s, copro_ovf_r, copro_udf_r,
                      2'b00, ~rsp_empty_s, copro_irq_en_r};
    if (!host_cs) begin
      host_dout = 8'h00;
    end else if (host_a) begin
      host_dout = host_status_s;
    end else begin
      host_dout = rsp_head_s;
    end
    if (!copro_cs) begin
      copro_dout = 8'h00;
    end else if (copro_a) begin
      copro_dout = copro_status_s;
    end else begin
      copro_dout = cmd_head_s;
    end
  end

  assign _irq_host = irq_host_r;
  assign _irq_09   = irq_09_r;

endmodule
